// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared state type, counter constants and default 640x480 timing
// for the VGA sync receiver.
package vga_timing_pkg;

  localparam int unsigned CntW = 11;
  localparam logic [CntW-1:0] CntMax = 11'd2047;

  localparam int unsigned DefHSyncW     = 96;
  localparam int unsigned DefHBp        = 48;
  localparam int unsigned DefHActive    = 640;
  localparam int unsigned DefVSyncW     = 2;
  localparam int unsigned DefVBp        = 33;
  localparam int unsigned DefVActive    = 480;
  localparam int unsigned DefLockFrames = 2;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StMeasure = 2'd1,
    StLocked  = 2'd2
  } rx_state_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] val);
    return (val == CntMax) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: one-cycle pulse on the falling edge of an active-low sync input.
// With VGA_RX_INPUT_SYNC_EN defined the input first crosses a two-flop synchronizer.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic fall_o
);

  logic sync_s;

`ifdef VGA_RX_INPUT_SYNC_EN
  logic [1:0] meta_q, meta_d;

  always_comb begin
    meta_d = {meta_q[0], sync_i};
  end

  // Reset high so a released reset never looks like a falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 2'b11;
    end else begin
      meta_q <= meta_d;
    end
  end

  assign sync_s = meta_q[1];
`else
  assign sync_s = sync_i;
`endif

  logic prev_q, prev_d;

  always_comb begin
    prev_d = sync_s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign fall_o = prev_q & ~sync_s;

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: measures line/frame periods from H_SYNC/V_SYNC, locks after LOCK_FRAMES
// identical frames and emits raster coordinates. VGA_RX_INPUT_SYNC_EN adds input synchronizers.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC_W    = DefHSyncW,
  parameter int unsigned H_BP        = DefHBp,
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned V_SYNC_W    = DefVSyncW,
  parameter int unsigned V_BP        = DefVBp,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned LOCK_FRAMES = DefLockFrames
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            H_SYNC,
  input  logic            V_SYNC,
  output logic [9:0]      PIXEL_X,
  output logic [9:0]      PIXEL_Y,
  output logic            ACTIVE,
  output logic            LOCKED,
  output logic            FRAME_START,
  output logic            SYNC_LOST,
  output logic [CntW-1:0] H_PERIOD,
  output logic [CntW-1:0] V_LINES
);

  localparam logic [CntW-1:0] HsStart = CntW'(H_SYNC_W + H_BP);
  localparam logic [CntW-1:0] HsEnd   = CntW'(H_SYNC_W + H_BP + H_ACTIVE);
  localparam logic [CntW-1:0] VsStart = CntW'(V_SYNC_W + V_BP);
  localparam logic [CntW-1:0] VsEnd   = CntW'(V_SYNC_W + V_BP + V_ACTIVE);
  localparam logic [2:0]      LockCnt = 3'(LOCK_FRAMES);

  logic hfall, vfall;

  sync_edge_detect u_hsync_edge (
    .clk_i  (CLK),
    .rst_i  (RST),
    .sync_i (H_SYNC),
    .fall_o (hfall)
  );

  sync_edge_detect u_vsync_edge (
    .clk_i  (CLK),
    .rst_i  (RST),
    .sync_i (V_SYNC),
    .fall_o (vfall)
  );

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] h_cnt_q, h_cnt_d;
  logic [CntW-1:0] v_cnt_q, v_cnt_d;
  logic [CntW-1:0] h_period_q, h_period_d;
  logic [CntW-1:0] v_lines_q, v_lines_d;
  logic            h_seen_q, h_seen_d;
  logic            h_valid_q, h_valid_d;
  logic            v_seen_q, v_seen_d;
  logic            v_valid_q, v_valid_d;
  logic            line_bad_q, line_bad_d;
  logic [2:0]      good_cnt_q, good_cnt_d;
  logic            frame_start_q, frame_start_d;
  logic            sync_lost_q, sync_lost_d;

  logic [CntW-1:0] h_meas, v_meas;
  logic            line_bad_now, frame_good, h_sat, enter_search;
  logic [2:0]      good_next;

  always_comb begin
    h_meas       = h_cnt_q + 1'b1;
    v_meas       = v_cnt_q + 1'b1;
    h_sat        = (h_cnt_q == CntMax);
    line_bad_now = hfall & h_valid_q & (h_meas != h_period_q);
    // A mismatch on the very hfall that coincides with vfall still spoils the frame.
    frame_good   = v_valid_q & ~line_bad_q & ~line_bad_now & (v_meas == v_lines_q);
    good_next    = frame_good ? good_cnt_q + 3'd1 : 3'd0;

    h_cnt_d    = hfall ? '0 : sat_inc(h_cnt_q);
    v_cnt_d    = vfall ? '0 : (hfall ? sat_inc(v_cnt_q) : v_cnt_q);
    h_period_d = hfall ? h_meas : h_period_q;
    v_lines_d  = vfall ? v_meas : v_lines_q;
    line_bad_d = vfall ? 1'b0 : (line_bad_q | line_bad_now);

    // Valid flags rise on the second event after entering search.
    h_seen_d  = h_seen_q | hfall;
    h_valid_d = h_valid_q | (hfall & h_seen_q);
    v_seen_d  = v_seen_q | vfall;
    v_valid_d = v_valid_q | (vfall & v_seen_q);

    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    frame_start_d = 1'b0;
    sync_lost_d   = 1'b0;
    enter_search  = 1'b0;

    unique case (state_q)
      StSearch: begin
        if (vfall) begin
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (vfall && !h_sat) begin
          good_cnt_d = good_next;
          if (good_next == LockCnt) begin
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (line_bad_now || h_sat || (vfall && !frame_good)) begin
          state_d      = StSearch;
          sync_lost_d  = 1'b1;
          enter_search = 1'b1;
        end else if (vfall) begin
          frame_start_d = 1'b1;
        end
      end
      default: begin
        state_d      = StSearch;
        enter_search = 1'b1;
      end
    endcase

    if (enter_search) begin
      h_seen_d   = 1'b0;
      h_valid_d  = 1'b0;
      v_seen_d   = 1'b0;
      v_valid_d  = 1'b0;
      good_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StSearch;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_period_q    <= '0;
      v_lines_q     <= '0;
      h_seen_q      <= 1'b0;
      h_valid_q     <= 1'b0;
      v_seen_q      <= 1'b0;
      v_valid_q     <= 1'b0;
      line_bad_q    <= 1'b0;
      good_cnt_q    <= 3'd0;
      frame_start_q <= 1'b0;
      sync_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_period_q    <= h_period_d;
      v_lines_q     <= v_lines_d;
      h_seen_q      <= h_seen_d;
      h_valid_q     <= h_valid_d;
      v_seen_q      <= v_seen_d;
      v_valid_q     <= v_valid_d;
      line_bad_q    <= line_bad_d;
      good_cnt_q    <= good_cnt_d;
      frame_start_q <= frame_start_d;
      sync_lost_q   <= sync_lost_d;
    end
  end

  always_comb begin
    ACTIVE  = (state_q == StLocked) &&
              (h_cnt_q >= HsStart) && (h_cnt_q < HsEnd) &&
              (v_cnt_q >= VsStart) && (v_cnt_q < VsEnd);
    PIXEL_X = ACTIVE ? 10'(h_cnt_q - HsStart) : '0;
    PIXEL_Y = ACTIVE ? 10'(v_cnt_q - VsStart) : '0;
  end

  assign LOCKED      = (state_q == StLocked);
  assign FRAME_START = frame_start_q;
  assign SYNC_LOST   = sync_lost_q;
  assign H_PERIOD    = h_period_q;
  assign V_LINES     = v_lines_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: small-raster bench (32-clock lines, 16-line frames) with an
// event-timestamp reference model, a coordinate probe table and directed loss cases.
module tb_vga_sync_receiver;

  localparam int HSW = 4, HBP = 4, HA = 16, VSW = 1, VBP = 2, VA = 8, LF = 2;
  localparam int LINE = 32, FRAME_L = 16, HS = HSW + HBP, VS = VSW + VBP;

  logic        CLK = 1'b0;
  logic        RST, H_SYNC, V_SYNC;
  logic [9:0]  PIXEL_X, PIXEL_Y;
  logic        ACTIVE, LOCKED, FRAME_START, SYNC_LOST;
  logic [10:0] H_PERIOD, V_LINES;

  vga_sync_receiver #(
    .H_SYNC_W    (HSW),
    .H_BP        (HBP),
    .H_ACTIVE    (HA),
    .V_SYNC_W    (VSW),
    .V_BP        (VBP),
    .V_ACTIVE    (VA),
    .LOCK_FRAMES (LF)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .H_SYNC      (H_SYNC),
    .V_SYNC      (V_SYNC),
    .PIXEL_X     (PIXEL_X),
    .PIXEL_Y     (PIXEL_Y),
    .ACTIVE      (ACTIVE),
    .LOCKED      (LOCKED),
    .FRAME_START (FRAME_START),
    .SYNC_LOST   (SYNC_LOST),
    .H_PERIOD    (H_PERIOD),
    .V_LINES     (V_LINES)
  );

  always #5 CLK = ~CLK;

  int n_tests, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: works from edge timestamps and event counts.
  longint cyc, m_last_h;
  int     m_nh, m_hseen, m_vseen, m_hper, m_vlines, m_good, m_mode; // mode 0/1/2
  bit     m_ph, m_pv, m_lbad, e_fs, e_sl;

  task automatic model_reset();
    cyc = 0; m_last_h = 0; m_nh = 0; m_ph = 1; m_pv = 1;
    m_hseen = 0; m_vseen = 0; m_hper = 0; m_vlines = 0; m_lbad = 0;
    m_good = 0; m_mode = 0; e_fs = 0; e_sl = 0;
  endtask

  task automatic model_step(input bit h, input bit v);
    longint d;
    int  hcnt, vcnt;
    bit  hf, vf, hsat, bad_now, good;
    cyc++;
    hf = m_ph && !h;
    vf = m_pv && !v;
    d = cyc - m_last_h - 1;
    hcnt = (d > 2047) ? 2047 : int'(d);
    vcnt = (m_nh > 2047) ? 2047 : m_nh;
    hsat = (hcnt == 2047);
    bad_now = hf && (m_hseen >= 2) && (((hcnt + 1) % 2048) != m_hper);
    good = (m_vseen >= 2) && !m_lbad && !bad_now && (((vcnt + 1) % 2048) == m_vlines);
    e_fs = 0; e_sl = 0;
    if (hf) m_hper = (hcnt + 1) % 2048;
    if (vf) m_vlines = (vcnt + 1) % 2048;
    if (hf && m_hseen < 2) m_hseen++;
    if (vf && m_vseen < 2) m_vseen++;
    m_lbad = vf ? 1'b0 : (m_lbad || bad_now);
    if (m_mode == 0) begin
      if (vf) m_mode = 1;
    end else if (m_mode == 1) begin
      if (vf && !hsat) begin
        m_good = good ? m_good + 1 : 0;
        if (m_good == LF) m_mode = 2;
      end
    end else begin
      if (bad_now || hsat || (vf && !good)) begin
        m_mode = 0; e_sl = 1; m_hseen = 0; m_vseen = 0; m_good = 0;
      end else if (vf) begin
        e_fs = 1;
      end
    end
    if (hf) m_last_h = cyc;
    if (vf) m_nh = 0;
    else if (hf) m_nh++;
    m_ph = h; m_pv = v;
  endtask

  longint first_lock, last_fs, fs_gap;
  int     sl_cnt;

  task automatic step(input logic h, input logic v);
    longint hp;
    int  hn, vn, px, py;
    bit  act;
    H_SYNC = h; V_SYNC = v;
    @(posedge CLK);
    model_step(h, v);
    @(negedge CLK);
    hp = cyc - m_last_h;
    hn = (hp > 2047) ? 2047 : int'(hp);
    vn = (m_nh > 2047) ? 2047 : m_nh;
    act = (m_mode == 2) && hn >= HS && hn < HS + HA && vn >= VS && vn < VS + VA;
    px = act ? hn - HS : 0;
    py = act ? vn - VS : 0;
    check("cycle", {LOCKED, FRAME_START, SYNC_LOST, ACTIVE, PIXEL_X, PIXEL_Y, H_PERIOD, V_LINES},
          {m_mode == 2, e_fs, e_sl, act, 10'(px), 10'(py), 11'(m_hper), 11'(m_vlines)});
    if (FRAME_START) begin
      if (last_fs > 0) fs_gap = cyc - last_fs;
      last_fs = cyc;
    end
    if (SYNC_LOST) sl_cnt++;
    if (LOCKED && first_lock == 0) first_lock = cyc;
  endtask

  task automatic frame(input int nlines, input int odd_line, input int odd_len);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == odd_line) ? odd_len : LINE;
      for (int c = 0; c < len; c++) step(logic'(c >= HSW), logic'(l >= VSW));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_px"}, PIXEL_X, 0);
    check({tag, "_py"}, PIXEL_Y, 0);
    check({tag, "_active"}, ACTIVE, 0);
    check({tag, "_locked"}, LOCKED, 0);
    check({tag, "_fs"}, FRAME_START, 0);
    check({tag, "_sl"}, SYNC_LOST, 0);
    check({tag, "_hper"}, H_PERIOD, 0);
    check({tag, "_vlines"}, V_LINES, 0);
  endtask

  typedef struct {
    int         v;
    int         h;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
  } probe_t;

  probe_t probes[8];
  int     sl0;

  initial begin
    probes[0] = '{v: 3,  h: 8,  act: 1'b1, x: 10'd0,  y: 10'd0};
    probes[1] = '{v: 10, h: 23, act: 1'b1, x: 10'd15, y: 10'd7};
    probes[2] = '{v: 3,  h: 24, act: 1'b0, x: 10'd0,  y: 10'd0};
    probes[3] = '{v: 2,  h: 8,  act: 1'b0, x: 10'd0,  y: 10'd0};
    probes[4] = '{v: 11, h: 8,  act: 1'b0, x: 10'd0,  y: 10'd0};
    probes[5] = '{v: 3,  h: 7,  act: 1'b0, x: 10'd0,  y: 10'd0};
    probes[6] = '{v: 5,  h: 12, act: 1'b1, x: 10'd4,  y: 10'd2};
    probes[7] = '{v: 10, h: 8,  act: 1'b1, x: 10'd0,  y: 10'd7};

    n_tests = 0; n_fail = 0; first_lock = 0; last_fs = 0; fs_gap = 0; sl_cnt = 0;
    RST = 1'b1; H_SYNC = 1'b1; V_SYNC = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    model_reset();

    // Lock from reset: vfalls at edges 1, 513, 1025, 1537.
    repeat (4) frame(FRAME_L, -1, 0);
    check("lock_cycle", first_lock, 1537);
    frame(FRAME_L, -1, 0);
    check("locked", LOCKED, 1);
    check("h_period", H_PERIOD, 32);
    check("v_lines", V_LINES, 16);

    for (int l = 0; l < FRAME_L; l++) begin
      for (int c = 0; c < LINE; c++) begin
        step(logic'(c >= HSW), logic'(l >= VSW));
        for (int k = 0; k < 8; k++) begin
          if (probes[k].v == l && probes[k].h == c) begin
            check($sformatf("probe%0d_active", k), ACTIVE, probes[k].act);
            check($sformatf("probe%0d_x", k), PIXEL_X, probes[k].x);
            check($sformatf("probe%0d_y", k), PIXEL_Y, probes[k].y);
          end
        end
      end
    end
    check("fs_gap", fs_gap, 512);

    sl0 = sl_cnt;
    frame(FRAME_L, 5, 33);
    check("long_line_sl", sl_cnt - sl0, 1);
    check("long_line_unlocked", LOCKED, 0);
    repeat (3) frame(FRAME_L, -1, 0);
    check("long_line_not_yet", LOCKED, 0);
    frame(FRAME_L, -1, 0);
    check("long_line_relock", LOCKED, 1);

    sl0 = sl_cnt;
    frame(15, -1, 0);
    frame(FRAME_L, -1, 0);
    check("short_frame_sl", sl_cnt - sl0, 1);
    repeat (3) frame(FRAME_L, -1, 0);
    check("short_frame_not_yet", LOCKED, 0);
    frame(FRAME_L, -1, 0);
    check("short_frame_relock", LOCKED, 1);

    sl0 = sl_cnt;
    repeat (2100) step(1'b1, 1'b1);
    check("stuck_sl", sl_cnt - sl0, 1);
    check("stuck_active", ACTIVE, 0);
    check("stuck_locked", LOCKED, 0);
    repeat (4) frame(FRAME_L, -1, 0);
    check("stuck_relock", LOCKED, 1);

    for (int f = 0; f < 20; f++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) frame(15, -1, 0);
      else if (r == 1) frame(17, -1, 0);
      else if (r == 2) frame(FRAME_L, int'($urandom_range(1, 15)), ($urandom_range(0, 1) != 0) ? 33 : 31);
      else frame(FRAME_L, -1, 0);
    end

    repeat (5) frame(FRAME_L, -1, 0);
    check("pre_reset_locked", LOCKED, 1);
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < LINE; c++) step(logic'(c >= HSW), logic'(l >= VSW));
    for (int c = 0; c < 10; c++) step(logic'(c >= HSW), 1'b1);
    check("pre_reset_active", ACTIVE, 1);
    check("pre_reset_px", PIXEL_X, 1);
    check("pre_reset_py", PIXEL_Y, 1);
    #2 RST = 1'b1;
    #1 check_all_zero("midline_reset");
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    repeat (4) frame(FRAME_L, -1, 0);
    check("post_reset_relock", LOCKED, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
